// File: rtl/loop_nest_counter.sv
// N-level nested loop counter: level 0 innermost, carries ripple outward.
// Start latches limit/step and runs the nest; Done pulses once after the final iteration.

module loop_nest_level #(
    parameter int BITWIDTH = 10
) (
    input  logic [BITWIDTH-1:0] count,
    input  logic [BITWIDTH-1:0] limit,
    input  logic [BITWIDTH-1:0] step,
    input  logic                carry_in,
    output logic [BITWIDTH-1:0] next_count,
    output logic                carry_out,
    output logic                eqn
);
    logic [BITWIDTH-1:0] step_eff;
    logic [BITWIDTH:0]   sum;
    logic                at_end;

    // Zero stride would stall the nest forever, so it behaves as a stride of one.
    assign step_eff   = (step == '0) ? {{(BITWIDTH-1){1'b0}}, 1'b1} : step;
    assign sum        = {1'b0, count} + {1'b0, step_eff};
    assign at_end     = sum > {1'b0, limit};
    assign next_count = carry_in ? (at_end ? '0 : sum[BITWIDTH-1:0]) : count;
    assign carry_out  = carry_in & at_end;
    assign eqn        = (count == limit);
endmodule

module loop_nest_counter #(
    parameter int BITWIDTH = 10,
    parameter int LEVELS   = 3
) (
    input  logic                         LOOPCNT_Clk,
    input  logic                         LOOPCNT_Clr,
    input  logic                         LOOPCNT_Start,
    input  logic                         LOOPCNT_En,
    input  logic                         LOOPCNT_Abort,
    input  logic                         LOOPCNT_Load,
    input  logic [LEVELS*BITWIDTH-1:0]   LOOPCNT_Data,
    input  logic [LEVELS*BITWIDTH-1:0]   LOOPCNT_Limit,
    input  logic [LEVELS*BITWIDTH-1:0]   LOOPCNT_Step,
    output logic [LEVELS*BITWIDTH-1:0]   LOOPCNT_Out,
    output logic [LEVELS-1:0]            LOOPCNT_Eqn_Flag,
    output logic [LEVELS-1:0]            LOOPCNT_Wrap,
    output logic                         LOOPCNT_Busy,
    output logic                         LOOPCNT_Done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                             state;
    logic [LEVELS-1:0][BITWIDTH-1:0]    cnt;
    logic [LEVELS-1:0][BITWIDTH-1:0]    lim_q;
    logic [LEVELS-1:0][BITWIDTH-1:0]    step_q;
    logic [LEVELS-1:0][BITWIDTH-1:0]    nxt;
    logic [LEVELS-1:0][BITWIDTH-1:0]    data_in;
    logic [LEVELS-1:0][BITWIDTH-1:0]    limit_in;
    logic [LEVELS-1:0][BITWIDTH-1:0]    step_in;
    logic [LEVELS:0]                    carry;
    logic [LEVELS-1:0]                  eqn;
    logic [LEVELS-1:0]                  wrap;
    logic                               busy;
    logic                               done;

    assign data_in  = LOOPCNT_Data;
    assign limit_in = LOOPCNT_Limit;
    assign step_in  = LOOPCNT_Step;
    assign carry[0] = LOOPCNT_En;

    for (genvar i = 0; i < LEVELS; i++) begin : g_level
        loop_nest_level #(.BITWIDTH(BITWIDTH)) u_level (
            .count      (cnt[i]),
            .limit      (lim_q[i]),
            .step       (step_q[i]),
            .carry_in   (carry[i]),
            .next_count (nxt[i]),
            .carry_out  (carry[i+1]),
            .eqn        (eqn[i])
        );
    end

    // Priority: Clr > Abort > Start > Load > En. Wrap and Done are single-cycle pulses.
    always_ff @(posedge LOOPCNT_Clk) begin
        if (!LOOPCNT_Clr) begin
            state  <= IDLE;
            cnt    <= '0;
            lim_q  <= '0;
            step_q <= '0;
            wrap   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            wrap <= '0;
            done <= 1'b0;
            if (LOOPCNT_Abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (LOOPCNT_Start) begin
                lim_q  <= limit_in;
                step_q <= step_in;
                cnt    <= '0;
                state  <= RUN;
                busy   <= 1'b1;
            end else if (LOOPCNT_Load && state != DONE) begin
                cnt <= data_in;
            end else begin
                case (state)
                    RUN: begin
                        if (LOOPCNT_En) begin
                            cnt  <= nxt;
                            wrap <= carry[LEVELS:1];
                            if (carry[LEVELS]) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign LOOPCNT_Out      = cnt;
    assign LOOPCNT_Eqn_Flag = eqn;
    assign LOOPCNT_Wrap     = wrap;
    assign LOOPCNT_Busy     = busy;
    assign LOOPCNT_Done     = done;
endmodule
